// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, default oversampling ratio and
// the majority-vote helper used by the RX front-end filters.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOW, BREAK} line_state_t;

  localparam int OVER_SAMPLE_DEF = 8;
  localparam int MAJ_MAX_W       = 32;

  // Majority of the lowest `taps` bits of vec; taps is odd, so no ties.
  function automatic logic majority(input logic [MAJ_MAX_W-1:0] vec, input int taps);
    int ones;
    ones = 0;
    for (int i = 0; i < MAJ_MAX_W; i++) begin
      if (i < taps && vec[i]) ones++;
    end
    return (2 * ones > taps);
  endfunction

endpackage

// File: rtl/uart_sync_filter.sv
// RX pin synchroniser followed by a registered majority filter over the last
// FilterTaps synced samples. Optional glitch counter: UART_RX_SAMPLER_GLITCH_CNT_EN.
module uart_sync_filter
  import uart_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int FilterTaps = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_async,
  output logic       o_filt
`ifdef UART_RX_SAMPLER_GLITCH_CNT_EN
  , output logic [7:0] o_glitch_cnt
`endif
);

  logic [SyncStages-1:0] meta;
  logic [FilterTaps-2:0] f_hist;
  logic [FilterTaps-1:0] window;
  logic                  sync;

  assign sync   = meta[SyncStages-1];
  // The vote covers the window as it stands after this edge, so a clean step
  // needs only (FilterTaps+1)/2 synced samples to pass.
  assign window = {f_hist, sync};

  // Stage boundary: synchroniser and filter history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta   <= '1;
      f_hist <= '1;
      o_filt <= 1'b1;
    end else begin
      meta   <= {meta[SyncStages-2:0], i_async};
      f_hist <= window[FilterTaps-2:0];
      o_filt <= majority(MAJ_MAX_W'(window), FilterTaps);
    end
  end

`ifdef UART_RX_SAMPLER_GLITCH_CNT_EN
  logic glitch;

  // Isolated 1-0-1 or 0-1-0 across three consecutive synced samples.
  assign glitch = (sync == f_hist[1]) && (sync != f_hist[0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_glitch_cnt <= 8'h00;
    end else if (glitch && o_glitch_cnt != 8'hFF) begin
      o_glitch_cnt <= o_glitch_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX line front end: filtered RX bit, oversampling prescaler pulses and
// start/break line tracking. Optional feature macro: UART_RX_SAMPLER_GLITCH_CNT_EN.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OverSample = OVER_SAMPLE_DEF,
  parameter int SyncStages = 2,
  parameter int FilterTaps = 3,
  parameter int BreakBits  = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_pin,
  input  logic       i_prescaler_en,
  output logic       o_rx,
  output logic       o_strobe,
  output logic       o_half,
  output logic       o_start,
  output logic       o_break
`ifdef UART_RX_SAMPLER_GLITCH_CNT_EN
  , output logic [7:0] o_glitch_cnt
`endif
);

  localparam int Thresh = OverSample * BreakBits;
  localparam int LowW   = $clog2(Thresh + 1);
  localparam int CntW   = $clog2(OverSample);

  uart_sync_filter #(
    .SyncStages (SyncStages),
    .FilterTaps (FilterTaps)
  ) u_sync_filter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_async      (i_rx_pin),
    .o_filt       (o_rx)
`ifdef UART_RX_SAMPLER_GLITCH_CNT_EN
    , .o_glitch_cnt (o_glitch_cnt)
`endif
  );

  logic [CntW-1:0] pre_cnt;

  // Stage boundary: prescaler phase counter
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_prescaler_en) begin
      pre_cnt <= '0;
    end else if (pre_cnt == CntW'(OverSample - 1)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CntW'(1);
    end
  end

  assign o_half   = i_prescaler_en && (pre_cnt == CntW'(OverSample / 2 - 1));
  assign o_strobe = i_prescaler_en && (pre_cnt == CntW'(OverSample - 1));

  line_state_t     state, state_nxt;
  logic [LowW-1:0] low_cnt, low_cnt_nxt, low_inc;
  logic            rx_p1;
  logic            fall, rise;

  assign fall    = rx_p1 && !o_rx;
  assign rise    = !rx_p1 && o_rx;
  assign low_inc = (low_cnt == LowW'(Thresh)) ? low_cnt : low_cnt + LowW'(1);

  // Stage boundary: line state register and previous filtered bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      low_cnt <= '0;
      rx_p1   <= 1'b1;
    end else begin
      state   <= state_nxt;
      low_cnt <= low_cnt_nxt;
      rx_p1   <= o_rx;
    end
  end

  // A rise always beats the break threshold when both land on the same cycle.
  always_comb begin
    state_nxt   = state;
    low_cnt_nxt = low_cnt;
    o_start     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt   = LOW;
          low_cnt_nxt = LowW'(1);
          o_start     = 1'b1;
        end
      end
      LOW: begin
        low_cnt_nxt = low_inc;
        if (rise) begin
          state_nxt   = IDLE;
          low_cnt_nxt = '0;
        end else if (low_inc == LowW'(Thresh)) begin
          state_nxt = BREAK;
        end
      end
      BREAK: begin
        low_cnt_nxt = low_inc;
        if (rise) begin
          state_nxt   = IDLE;
          low_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        low_cnt_nxt = '0;
      end
    endcase
  end

  assign o_break = (state == BREAK);

endmodule
